// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
// Holds FSM state type, slice geometry and operand/term helpers.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W  = 3;
  localparam int N_SLICES = 3;
  localparam int TERMS    = 9;
  localparam int PROD_W   = 16;

  // 2-bit top slice is zero-extended to 3 bits
  function automatic logic [SLICE_W-1:0] get_slice(
    input logic [7:0] v,
    input logic [1:0] k
  );
    logic [SLICE_W-1:0] s;
    unique case (1'b1)
      (k == 2'd0): s = v[2:0];
      (k == 2'd1): s = v[5:3];
      default:     s = {1'b0, v[7:6]};
    endcase
    return s;
  endfunction

  // term index -> {row, col}; out-of-range maps to {0,0}
  function automatic logic [3:0] idx_rc(input logic [3:0] idx);
    logic [3:0] rc;
    unique case (1'b1)
      (idx == 4'd0): rc = {2'd0, 2'd0};
      (idx == 4'd1): rc = {2'd0, 2'd1};
      (idx == 4'd2): rc = {2'd0, 2'd2};
      (idx == 4'd3): rc = {2'd1, 2'd0};
      (idx == 4'd4): rc = {2'd1, 2'd1};
      (idx == 4'd5): rc = {2'd1, 2'd2};
      (idx == 4'd6): rc = {2'd2, 2'd0};
      (idx == 4'd7): rc = {2'd2, 2'd1};
      (idx == 4'd8): rc = {2'd2, 2'd2};
      default:       rc = 4'd0;
    endcase
    return rc;
  endfunction

  // weight of a term: 3*(row+col)
  function automatic logic [3:0] term_shift(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] s;
    s = {2'b0, row} + {2'b0, col};
    return (s << 1) + s;
  endfunction

endpackage

// File: rtl/pp_mult3.sv
// Combinational 3x3-bit unsigned multiply.
// Ports: x, y (3-bit operands), p (6-bit product).
module pp_mult3 (
  input  logic [2:0] x,
  input  logic [2:0] y,
  output logic [5:0] p
);

  assign p = {3'b0, x} * {3'b0, y};

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential 8x8 multiplier: nine 3x3 partial products, one per cycle.
// Ports: clk, rst_n, in_valid/in_ready/a/b, out_valid/out_ready/out_p, busy.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int PP_PIPE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p,
  output logic              busy
);

  // with the PP register, one extra CALC cycle drains the last term
  localparam int          LAST_I = TERMS - 1 + ((PP_PIPE != 0) ? 1 : 0);
  localparam logic [3:0]  LAST   = 4'(LAST_I);

  state_t            state;
  logic [3:0]        idx;
  logic [PROD_W-1:0] acc;
  logic [7:0]        a_q;
  logic [7:0]        b_q;
  logic [5:0]        pp_q;
  logic [3:0]        pp_sh;
  logic              pp_vld;

  logic [1:0]        row;
  logic [1:0]        col;
  logic [2:0]        rs;
  logic [2:0]        cs;
  logic [5:0]        term;
  logic [3:0]        sh;
  logic [PROD_W-1:0] addend;

  always_comb begin
    {row, col} = idx_rc(idx);
    rs = get_slice(a_q, row);
    cs = get_slice(b_q, col);
    sh = term_shift(row, col);
    addend = '0;
    if (PP_PIPE != 0) begin
      if (pp_vld) addend = PROD_W'(pp_q) << pp_sh;
    end else begin
      addend = PROD_W'(term) << sh;
    end
  end

  pp_mult3 u_pp (
    .x (rs),
    .y (cs),
    .p (term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      acc    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      pp_q   <= '0;
      pp_sh  <= '0;
      pp_vld <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            acc    <= '0;
            idx    <= '0;
            pp_q   <= '0;
            pp_sh  <= '0;
            pp_vld <= 1'b0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc <= acc + addend;
          idx <= idx + 4'd1;
          if (PP_PIPE != 0) begin
            pp_q   <= term;
            pp_sh  <= sh;
            pp_vld <= (idx != 4'(TERMS));
          end
          if (idx == LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // gated by rst_n so nothing is accepted while reset is held
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign out_p     = out_valid ? acc : '0;
  assign busy      = (state == CALC);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl, PP_PIPE=0 (dut 0) and 1 (dut 1).
// Directed vectors, corner sequences and random traffic vs a queue model.
module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        iv   [2];
  logic        ir   [2];
  logic [7:0]  av   [2];
  logic [7:0]  bv   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [15:0] op   [2];
  logic        bz   [2];

  int total;
  int bad;

  mult_seq_ctrl #(.PP_PIPE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_p(op[0]), .busy(bz[0])
  );

  mult_seq_ctrl #(.PP_PIPE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_p(op[1]), .busy(bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input int d, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h", nm, d, act, exp);
    end
  endtask

  // latency counts the accept edge itself as the first clock
  task automatic run_one(input int d, input logic [7:0] x,
                         input logic [7:0] y, input logic [15:0] e,
                         input int lat);
    int cyc;
    chk(d, "pre_ready", 32'(ir[d]), 1);
    iv[d] = 1'b1; av[d] = x; bv[d] = y; ordy[d] = 1'b0;
    @(negedge clk);
    iv[d] = 1'b0;
    cyc = 1;
    while (!ov[d] && cyc < 40) begin
      chk(d, "calc_busy", 32'(bz[d]), 1);
      chk(d, "calc_p0", 32'(op[d]), 0);
      @(negedge clk);
      cyc++;
    end
    chk(d, "latency", 32'(cyc), 32'(lat));
    chk(d, "product", 32'(op[d]), 32'(e));
    chk(d, "busy_done", 32'(bz[d]), 0);
    ordy[d] = 1'b1;
    @(negedge clk);
    ordy[d] = 1'b0;
    chk(d, "ov_after", 32'(ov[d]), 0);
    chk(d, "p_after", 32'(op[d]), 0);
    chk(d, "ready_after", 32'(ir[d]), 1);
  endtask

  task automatic rand_traffic(input int d, input int n);
    logic [15:0] q[$];
    logic [15:0] e;
    int sent;
    int got;
    int cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < n && cyc < n * 40) begin
      @(negedge clk);
      cyc++;
      if (!ov[d]) chk(d, "rand_p0", 32'(op[d]), 0);
      iv[d]   = (sent < n) && ($urandom_range(0, 3) != 0);
      av[d]   = 8'($urandom);
      bv[d]   = 8'($urandom);
      ordy[d] = 1'($urandom_range(0, 1));
      if (iv[d] && ir[d]) begin
        q.push_back(16'(int'(av[d]) * int'(bv[d])));
        sent++;
      end
      if (ov[d] && ordy[d]) begin
        if (q.size() == 0) begin
          chk(d, "rand_extra", 32'(op[d]), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk(d, "rand_p", 32'(op[d]), 32'(e));
        end
        got++;
      end
    end
    @(negedge clk);
    iv[d] = 1'b0;
    ordy[d] = 1'b0;
    chk(d, "rand_cnt", 32'(got), 32'(n));
    chk(d, "rand_left", 32'(q.size()), 0);
  endtask

  initial begin
    int cyc;
    int extra;
    total = 0;
    bad = 0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; av[d] = '0; bv[d] = '0; ordy[d] = 1'b0;
    end

    vecs[0] = '{8'h00, 8'hFF, 16'h0000};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'hA5, 8'h3C, 16'h26AC};
    vecs[3] = '{8'h07, 8'h09, 16'h003F};
    vecs[4] = '{8'h80, 8'h80, 16'h4000};
    vecs[5] = '{8'hFF, 8'h01, 16'h00FF};
    vecs[6] = '{8'h01, 8'h01, 16'h0001};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_ready", 32'(ir[d]), 0);
      chk(d, "rst_ov", 32'(ov[d]), 0);
      chk(d, "rst_p", 32'(op[d]), 0);
      chk(d, "rst_busy", 32'(bz[d]), 0);
    end
    rst_n = 1'b1;
    #1;
    chk(0, "rel_ready", 32'(ir[0]), 1);
    chk(1, "rel_ready", 32'(ir[1]), 1);
    @(negedge clk);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 7; i++)
        run_one(d, vecs[i].a, vecs[i].b, vecs[i].p, 10 + d);

    // backpressure
    iv[0] = 1'b1; av[0] = 8'hFF; bv[0] = 8'hFF;
    @(negedge clk);
    iv[0] = 1'b0;
    cyc = 0;
    while (!ov[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      chk(0, "bp_ov", 32'(ov[0]), 1);
      chk(0, "bp_p", 32'(op[0]), 32'hFE01);
      chk(0, "bp_ready", 32'(ir[0]), 0);
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk(0, "bp_rel_ready", 32'(ir[0]), 1);

    // in_valid while busy must be ignored
    iv[0] = 1'b1; av[0] = 8'hA5; bv[0] = 8'h3C;
    @(negedge clk);
    iv[0] = 1'b0;
    cyc = 1;
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    chk(0, "ign_busy", 32'(bz[0]), 1);
    iv[0] = 1'b1; av[0] = 8'h12; bv[0] = 8'h34;
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    iv[0] = 1'b0;
    while (!ov[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk(0, "ign_lat", 32'(cyc), 10);
    chk(0, "ign_p", 32'(op[0]), 32'h26AC);
    ordy[0] = 1'b1;
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (ov[0]) extra++;
    end
    ordy[0] = 1'b0;
    chk(0, "ign_extra", 32'(extra), 0);

    // reset in the middle of CALC (idx=4)
    iv[0] = 1'b1; av[0] = 8'hFF; bv[0] = 8'hFF;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk(0, "mid_busy", 32'(bz[0]), 1);
    rst_n = 1'b0;
    #1;
    chk(0, "mid_ready", 32'(ir[0]), 0);
    chk(0, "mid_ov", 32'(ov[0]), 0);
    chk(0, "mid_p", 32'(op[0]), 0);
    chk(0, "mid_bz", 32'(bz[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov[0] || bz[0]) extra++;
    end
    chk(0, "mid_no_ov", 32'(extra), 0);
    run_one(0, 8'h07, 8'h09, 16'h003F, 10);

    fork
      rand_traffic(0, 3000);
      rand_traffic(1, 3000);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
